// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int         LEN_W         = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port of the loader.
interface imem_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  // Host / testbench side: drives the byte stream, observes memory writes.
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  // Loader side.
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs bytes little-endian into a 32-bit word, one lane per load.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] word_q;

  // Current register contents with the incoming byte dropped into its lane;
  // this is the complete word in the cycle the last lane arrives.
  always_comb begin
    word                     = word_q;
    word[{lane, 3'b000} +: 8] = din;
  end

  assign word_full = load && (lane == 2'd3);

  // Holding register for the partially assembled word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
    end else if (clear) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses MAGIC/LEN/payload/CHK frames, writes instruction memory
// word by word and releases the core from reset only after a good checksum.
module imem_loader
  import loader_pkg::*;
#(
  parameter int         MAX_WORDS = 256,
  parameter logic [7:0] MAGIC     = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  imem_loader_if.slave      bus,
  output logic              core_resetn,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W:0] MAX_N = (LEN_W + 1)'(MAX_WORDS);

  state_t           state, state_n;
  logic             run_q;
  logic [7:0]       chk_q;
  logic [7:0]       len_lo_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  logic [LEN_W-1:0] len_n;
  logic             acc;
  logic             asm_clear;
  logic             asm_load;
  logic [31:0]      asm_word;
  logic             asm_full;
  logic             last_word;

  // run_q keeps rx_ready low while reset is held and for the release cycle.
  assign bus.rx_ready = run_q && (state != S_DONE) && (state != S_ERROR) && !restart;
  assign acc          = bus.rx_valid && bus.rx_ready;
  assign len_n        = {bus.rx_data, len_lo_q};
  assign asm_clear    = acc && (state == S_IDLE) && (bus.rx_data == MAGIC);
  assign asm_load     = acc && (state == S_DATA);
  assign last_word    = (word_idx == len_q - 1'b1);

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .load      (asm_load),
    .lane      (byte_idx),
    .din       (bus.rx_data),
    .word      (asm_word),
    .word_full (asm_full)
  );

  // State register plus the enable that opens the byte port after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      run_q <= 1'b0;
    end else begin
      state <= state_n;
      run_q <= 1'b1;
    end
  end

  // Frame parser next-state; restart overrides everything.
  always_comb begin
    state_n = state;
    if (restart) begin
      state_n = S_IDLE;
    end else if (acc) begin
      unique case (state)
        S_IDLE:  if (bus.rx_data == MAGIC) state_n = S_LEN0;
        S_LEN0:  state_n = S_LEN1;
        S_LEN1: begin
          if ({1'b0, len_n} > MAX_N)    state_n = S_ERROR;
          else if (len_n == '0)         state_n = S_CHECK;
          else                          state_n = S_DATA;
        end
        S_DATA:  if (asm_full && last_word) state_n = S_CHECK;
        S_CHECK: state_n = (bus.rx_data == chk_q) ? S_DONE : S_ERROR;
        default: state_n = state;
      endcase
    end
  end

  // Length latch, running checksum and word/byte counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_q    <= '0;
      len_lo_q <= '0;
      len_q    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
    end else if (acc) begin
      unique case (state)
        S_IDLE: begin
          if (bus.rx_data == MAGIC) begin
            chk_q    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        S_LEN0: len_lo_q <= bus.rx_data;
        S_LEN1: len_q    <= len_n;
        S_DATA: begin
          chk_q    <= chk_q ^ bus.rx_data;
          byte_idx <= byte_idx + 2'd1;
          if (asm_full) word_idx <= word_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered memory write port and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      core_resetn    <= 1'b0;
    end else begin
      bus.imem_we <= asm_full;
      if (asm_full) begin
        bus.imem_addr  <= {{(32 - LEN_W - 2){1'b0}}, word_idx, 2'b00};
        bus.imem_wdata <= asm_word;
      end
      done        <= (state_n == S_DONE);
      error       <= (state_n == S_ERROR);
      core_resetn <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
module tb_imem_loader;
  import loader_pkg::*;

  logic clk;
  logic reset;
  logic restart;
  logic core_resetn;
  logic done;
  logic error;
  int   checks;
  int   errors;
  int   wr_cnt;
  int   wr_base;

  imem_loader_if bus ();

  imem_loader #(.MAX_WORDS(256), .MAGIC(8'hA5)) dut (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .bus         (bus),
    .core_resetn (core_resetn),
    .done        (done),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count memory write pulses.
  always @(posedge clk) if (bus.imem_we === 1'b1) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", {31'd0, bus.rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    int n;
    n = $urandom_range(0, 2);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
    send(b);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    #1;
    check("ready_in_restart", {31'd0, bus.rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_rdy"},   {31'd0, bus.rx_ready}, 32'd0);
    check({tag, "_we"},    {31'd0, bus.imem_we},  32'd0);
    check({tag, "_addr"},  bus.imem_addr,         32'd0);
    check({tag, "_wdata"}, bus.imem_wdata,        32'd0);
    check({tag, "_corrn"}, {31'd0, core_resetn},  32'd0);
    check({tag, "_done"},  {31'd0, done},         32'd0);
    check({tag, "_err"},   {31'd0, error},        32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    wr_cnt       = 0;
    reset        = 1'b1;
    restart      = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Reset state
    #3;
    check_outputs_reset("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rdy_release", {31'd0, bus.rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rdy_after_rel", {31'd0, bus.rx_ready}, 32'd1);

    // Good 2-word frame preceded by garbage
    wr_base = wr_cnt;
    send(8'h00); send(8'h13);
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h50); send(8'h00);
    check("a_we0",   {31'd0, bus.imem_we}, 32'd1);
    check("a_addr0", bus.imem_addr,        32'h0000_0000);
    check("a_data0", bus.imem_wdata,       32'h0050_0013);
    send(8'h93);
    check("a_we_off", {31'd0, bus.imem_we}, 32'd0);
    send(8'h00); send(8'h10); send(8'h00);
    check("a_we1",   {31'd0, bus.imem_we}, 32'd1);
    check("a_addr1", bus.imem_addr,        32'h0000_0004);
    check("a_data1", bus.imem_wdata,       32'h0010_0093);
    check("a_done_early", {31'd0, done},   32'd0);
    send(8'hC0);
    check("a_done",  {31'd0, done},        32'd1);
    check("a_corrn", {31'd0, core_resetn}, 32'd1);
    check("a_err",   {31'd0, error},       32'd0);
    check("a_rdy",   {31'd0, bus.rx_ready}, 32'd0);
    check("a_wrcnt", wr_cnt - wr_base,     32'd2);
    do_restart();
    check("a_rs_done",  {31'd0, done},        32'd0);
    check("a_rs_corrn", {31'd0, core_resetn}, 32'd0);

    // Same frame, wrong checksum
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h50); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    send(8'hC1);
    check("b_err",   {31'd0, error},        32'd1);
    check("b_done",  {31'd0, done},         32'd0);
    check("b_corrn", {31'd0, core_resetn},  32'd0);
    check("b_rdy",   {31'd0, bus.rx_ready}, 32'd0);
    do_restart();
    check("b_rs_err", {31'd0, error}, 32'd0);

    // Oversize length 257
    wr_base = wr_cnt;
    send(8'hA5); send(8'h01);
    check("c_err_early", {31'd0, error}, 32'd0);
    send(8'h01);
    check("c_err",   {31'd0, error},   32'd1);
    check("c_wrcnt", wr_cnt - wr_base, 32'd0);
    do_restart();

    // Empty frame
    wr_base = wr_cnt;
    send(8'hA5); send(8'h00); send(8'h00);
    check("d_done_early", {31'd0, done}, 32'd0);
    send(8'h00);
    check("d_done",  {31'd0, done},        32'd1);
    check("d_corrn", {31'd0, core_resetn}, 32'd1);
    check("d_wrcnt", wr_cnt - wr_base,     32'd0);
    do_restart();

    // 4-word frame with gaps, aborted by restart on a payload byte
    wr_base = wr_cnt;
    send_gap(8'hA5); send_gap(8'h04); send_gap(8'h00);
    send_gap(8'h01); send_gap(8'h02); send_gap(8'h03); send_gap(8'h04);
    check("e_data0", bus.imem_wdata, 32'h0403_0201);
    send_gap(8'h05); send_gap(8'h06); send_gap(8'h07); send_gap(8'h08);
    check("e_addr1", bus.imem_addr,  32'h0000_0004);
    check("e_data1", bus.imem_wdata, 32'h0807_0605);
    @(negedge clk);
    bus.rx_data  = 8'h09;
    bus.rx_valid = 1'b1;
    do_restart();
    bus.rx_valid = 1'b0;
    check("e_wrcnt", wr_cnt - wr_base, 32'd2);
    check("e_done",  {31'd0, done},    32'd0);
    check("e_err",   {31'd0, error},   32'd0);
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("e_addr_new", bus.imem_addr,  32'h0000_0000);
    check("e_data_new", bus.imem_wdata, 32'h4433_2211);
    send(8'h44);
    check("e_done_new", {31'd0, done}, 32'd1);
    do_restart();

    // Asynchronous reset mid-DATA
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'hAB); send(8'hCD); send(8'hEF); send(8'h12);
    check("f_we_pre", {31'd0, bus.imem_we}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_reset("f_async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    check("f_addr", bus.imem_addr,  32'h0000_0000);
    check("f_data", bus.imem_wdata, 32'hDDCC_BBAA);
    send(8'h00);
    check("f_done",  {31'd0, done},        32'd1);
    check("f_corrn", {31'd0, core_resetn}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
